// File: rtl/z80_host_bridge_if.sv
// Signal bundle between the Z80 bus / GPU RAM host port and z80_host_bridge.
// The bridge uses the slave view; the Z80 side and RAM model use the master view.
interface z80_host_bridge_if;
  logic        z80_mreq_n;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic [19:0] z80_addr;
  logic [7:0]  z80_data_in;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe;
  logic        z80_wait_n;
  logic        ram_wr_ena;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_rd_data;

  modport slave (
    input  z80_mreq_n, z80_rd_n, z80_wr_n, z80_addr, z80_data_in, ram_rd_data,
    output z80_data_out, z80_data_oe, z80_wait_n, ram_wr_ena, ram_addr, ram_wr_data
  );

  modport master (
    output z80_mreq_n, z80_rd_n, z80_wr_n, z80_addr, z80_data_in, ram_rd_data,
    input  z80_data_out, z80_data_oe, z80_wait_n, ram_wr_ena, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/z80_host_bridge.sv
// Bridges asynchronous Z80 memory cycles onto the GPU RAM host port in the clk domain.
// Writes become a single-clock pulse; reads hold WAIT low until RAM data is captured.
module z80_host_bridge #(
  parameter logic [19:0] MEM_BASE     = 20'h00000,
  parameter logic [19:0] MEM_SIZE     = 20'h04000,
  parameter int unsigned READ_LATENCY = 6,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  z80_host_bridge_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  state_t                 state_r;
  logic [3:0]             cnt_r;
  logic [SYNC_STAGES-1:0] mreq_sync_r;
  logic [SYNC_STAGES-1:0] rd_sync_r;
  logic [SYNC_STAGES-1:0] wr_sync_r;
  logic                   mreq_s;
  logic                   rd_s;
  logic                   wr_s;
  logic                   hit_s;

  logic        ram_wr_ena_r;
  logic [19:0] ram_addr_r;
  logic [7:0]  ram_wr_data_r;
  logic [7:0]  z80_data_out_r;
  logic        z80_data_oe_r;
  logic        z80_wait_n_r;

  // The offset is taken modulo 2^20, so the lower-bound test is required too.
  function automatic logic in_window(input logic [19:0] addr);
    logic [19:0] offset;
    offset = addr - MEM_BASE;
    return (addr >= MEM_BASE) && (offset < MEM_SIZE);
  endfunction

  // Strobe synchronisers, preset to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_sync_r <= {SYNC_STAGES{1'b1}};
      rd_sync_r   <= {SYNC_STAGES{1'b1}};
      wr_sync_r   <= {SYNC_STAGES{1'b1}};
    end else begin
      mreq_sync_r <= {mreq_sync_r[SYNC_STAGES-2:0], bus.z80_mreq_n};
      rd_sync_r   <= {rd_sync_r[SYNC_STAGES-2:0], bus.z80_rd_n};
      wr_sync_r   <= {wr_sync_r[SYNC_STAGES-2:0], bus.z80_wr_n};
    end
  end

  // Synchronised strobe taps and window decode.
  always_comb begin
    mreq_s = mreq_sync_r[SYNC_STAGES-1];
    rd_s   = rd_sync_r[SYNC_STAGES-1];
    wr_s   = wr_sync_r[SYNC_STAGES-1];
    hit_s  = in_window(bus.z80_addr);
  end

  // Access FSM; write strobe wins when RD and WR are both low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      ram_wr_ena_r   <= 1'b0;
      ram_addr_r     <= 20'h00000;
      ram_wr_data_r  <= 8'h00;
      z80_data_out_r <= 8'h00;
      z80_data_oe_r  <= 1'b0;
      z80_wait_n_r   <= 1'b1;
    end else begin
      ram_wr_ena_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!mreq_s && !wr_s) begin
            if (hit_s) begin
              ram_addr_r    <= bus.z80_addr;
              ram_wr_data_r <= bus.z80_data_in;
              ram_wr_ena_r  <= 1'b1;
              state_r       <= ST_WRITE;
            end else begin
              state_r <= ST_HOLD;
            end
          end else if (!mreq_s && !rd_s) begin
            if (hit_s) begin
              ram_addr_r   <= bus.z80_addr;
              z80_wait_n_r <= 1'b0;
              cnt_r        <= CNT_INIT;
              state_r      <= ST_READ;
            end else begin
              state_r <= ST_HOLD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          state_r <= ST_HOLD;
        end
        ST_READ: begin
          // An aborted cycle still finishes the read; HOLD then exits at once.
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            z80_data_out_r <= bus.ram_rd_data;
            z80_data_oe_r  <= 1'b1;
            z80_wait_n_r   <= 1'b1;
            state_r        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mreq_s) begin
            z80_data_oe_r <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          z80_data_oe_r <= 1'b0;
          z80_wait_n_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_wr_ena   = ram_wr_ena_r;
  assign bus.ram_addr     = ram_addr_r;
  assign bus.ram_wr_data  = ram_wr_data_r;
  assign bus.z80_data_out = z80_data_out_r;
  assign bus.z80_data_oe  = z80_data_oe_r;
  assign bus.z80_wait_n   = z80_wait_n_r;

endmodule

// File: doc/z80_host_bridge.md
Name: z80_host_bridge

Overview:
Bridges the asynchronous Z80 memory bus into the `clk` domain. It drives the single host port of the 16-port GPU RAM: `write_ena_host`, `addr_host_in` and `data_host_in`, and it consumes `data_host_out`. The Z80 strobes are synchronised, memory cycles that fall inside the GPU RAM window are decoded, and each hit becomes either a one-clock write pulse or a latency-counted read. Reads stretch the Z80 cycle with WAIT until the RAM data has been captured.

Parameters:
- MEM_BASE, 20'h00000, first Z80 address mapped to GPU RAM.
- MEM_SIZE, 20'h04000, window size in bytes; a hit requires MEM_BASE <= addr < MEM_BASE+MEM_SIZE.
- READ_LATENCY, 6, number of clk edges from a stable `ram_addr` to valid `ram_rd_data` (2..15).
- SYNC_STAGES, 2, synchroniser depth on the Z80 strobes (2..3).

Ports:
- clk, in, 1, system clock (125 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- z80_mreq_n, in, 1, Z80 MREQ; asynchronous to clk.
- z80_rd_n, in, 1, Z80 RD; asynchronous.
- z80_wr_n, in, 1, Z80 WR; asynchronous.
- z80_addr, in, 20, Z80 address; stable while MREQ is low.
- z80_data_in, in, 8, Z80 write data; stable while WR is low.
- z80_data_out, out, 8, read data returned to the Z80.
- z80_data_oe, out, 1, enables the Z80 data bus drivers.
- z80_wait_n, out, 1, Z80 WAIT, active low.
- ram_wr_ena, out, 1, connects to `write_ena_host`.
- ram_addr, out, 20, connects to `addr_host_in`.
- ram_wr_data, out, 8, connects to `data_host_in`.
- ram_rd_data, in, 8, driven from `data_host_out`.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ram_wr_ena=0; ram_addr=0; ram_wr_data=0; z80_data_out=0; z80_data_oe=0; z80_wait_n=1; synchronisers preset to 1 (idle).
- mreq_s, rd_s and wr_s are the SYNC_STAGES-deep synchronised strobes. z80_addr and z80_data_in are sampled only on the FSM transition out of IDLE.
- hit = (z80_addr >= MEM_BASE) && (z80_addr - MEM_BASE < MEM_SIZE). The subtraction is 20-bit unsigned.
- All outputs are registered.

FSM states: IDLE, WRITE, READ, HOLD.
- IDLE, when mreq_s=0, wr_s=0 and hit:
  - ram_addr <= z80_addr; ram_wr_data <= z80_data_in; ram_wr_ena <= 1; go to WRITE.
- IDLE, when mreq_s=0, rd_s=0 and hit:
  - ram_addr <= z80_addr; z80_wait_n <= 0; cnt <= READ_LATENCY-1; go to READ.
- IDLE, when mreq_s=0 with rd_s=0 or wr_s=0 but not hit:
  - go to HOLD with no RAM access, WAIT untouched, oe stays 0.
- IDLE, when rd_s and wr_s are both low: treated as a write.
- WRITE:
  - ram_wr_ena <= 0, so the pulse is exactly 1 clk; go to HOLD.
- READ, while cnt != 0: cnt decrements.
- READ, when cnt == 0:
  - z80_data_out <= ram_rd_data; z80_data_oe <= 1; z80_wait_n <= 1; go to HOLD.
- HOLD:
  - Waits for mreq_s=1, then z80_data_oe <= 0 and go to IDLE.
  - One Z80 cycle produces one access; no repeat while the strobe is held.
- ram_addr holds its last value between accesses, because the RAM host port reads continuously.
- Read timing: with strobe low first sampled at edge k, the FSM leaves IDLE at edge k+SYNC_STAGES and data is captured at edge k+SYNC_STAGES+READ_LATENCY.
- If MREQ rises during READ (Z80 abort), the read still completes, then HOLD exits immediately.
- Reset asserted mid-operation returns every output to its reset value immediately. No partial write pulse survives.
- ram_wr_ena is never asserted on a miss or during READ.

Test Plan:
- Write hit: MEM_BASE=0, addr 20'h01234, data 8'hA5, WR low for 20 clk -> ram_wr_ena high exactly 1 clk at edge k+2 (SYNC_STAGES=2) with ram_addr=01234 and ram_wr_data=A5. WAIT stays 1 and there is no second pulse.
- Read hit: READ_LATENCY=6, addr 20'h00010, RAM model returns 8'h3C after 6 clk -> z80_wait_n low for 6 clk, z80_data_out=3C, oe high until MREQ rises, then oe=0.
- Window miss: MEM_BASE=20'h10000, read at 20'h0FFFF then write at 20'h14000 (MEM_SIZE=4000) -> no ram_wr_ena, WAIT never asserted, oe=0. Address 20'h13FFF does hit.
- Back-to-back: write 8'h11 to 20'h00100, then read 20'h00100 after MREQ is high for 3 clk -> second access returns 11 and produces one write pulse total.
- Reset mid-read: assert rst_n=0 three clk after WAIT falls -> same-cycle z80_wait_n=1, oe=0, ram_wr_ena=0. After release with the strobe still low, one fresh read is serviced.
- Simultaneous RD and WR low on a hit: exactly one write pulse and no read data drive.
